// File: rtl/rv_plic_src_filter.sv
// Interrupt source conditioning ahead of the PLIC source inputs.
// Each source 1..NumSrc-1 is brought into the PLIC clock domain by a plain
// flop synchroniser. A per-source counter then requires the synchronised
// level to hold for filt_cycles_i+1 cycles before it is passed on. Rising
// and falling edges are treated the same way. Source 0 is tied low because
// the PLIC reserves it.
module rv_plic_src_filter #(
    parameter int unsigned        NumSrc     = 77,
    parameter int unsigned        SyncStages = 2,
    parameter int unsigned        FiltW      = 4,
    parameter logic [NumSrc-1:0]  FilterEn   = {NumSrc{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] src_async_i,
    input  logic [FiltW-1:0]  filt_cycles_i,
    output logic [NumSrc-1:0] intr_src_o,
    output logic [NumSrc-1:0] glitch_o
);

    // Source 0 is never used, so its raw input is deliberately left unconnected.
    logic unused_src0;
    assign unused_src0 = src_async_i[0];

    assign intr_src_o[0] = 1'b0;
    assign glitch_o[0]   = 1'b0;

    for (genvar s = 1; s < NumSrc; s++) begin : g_src
        // Synchroniser chain: stage 0 samples the raw line, the last stage is the sync level.
        logic [SyncStages-1:0] sync_p;
        logic                  sync_lvl;

        // Shift the raw level through SyncStages flops with no logic in between.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_p <= '0;
            end else begin
                sync_p <= {sync_p[SyncStages-2:0], src_async_i[s]};
            end
        end

        assign sync_lvl = sync_p[SyncStages-1];

        if (FilterEn[s]) begin : g_filt
            // Filter stage: out_p0 follows sync_lvl only after a long enough run.
            logic             out_p0;
            logic [FiltW-1:0] cnt_p0;

            // Count consecutive disagreeing cycles. Using >= means a lowered
            // threshold commits an in-flight change on the very next cycle,
            // and the counter can never wrap.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_p0 <= 1'b0;
                    cnt_p0 <= '0;
                end else if (sync_lvl == out_p0) begin
                    cnt_p0 <= '0;
                end else if (cnt_p0 >= filt_cycles_i) begin
                    out_p0 <= sync_lvl;
                    cnt_p0 <= '0;
                end else begin
                    cnt_p0 <= cnt_p0 + FiltW'(1);
                end
            end

            assign intr_src_o[s] = out_p0;
            // A pending change was abandoned: the level came back before qualifying.
            assign glitch_o[s]   = (sync_lvl == out_p0) && (cnt_p0 != '0);
        end else begin : g_byp
            // Bypass stage: one flop so the output is still registered.
            logic out_p0;

            // Follow the synchronised level every cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_p0 <= 1'b0;
                end else begin
                    out_p0 <= sync_lvl;
                end
            end

            assign intr_src_o[s] = out_p0;
            assign glitch_o[s]   = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_plic_src_filter.sv
// Bench for rv_plic_src_filter: directed scenarios plus a random soak.
// All outputs are compared against a behavioural model every cycle.
module tb_rv_plic_src_filter;

    localparam int NS = 77;
    localparam int SS = 2;
    localparam int FW = 4;
    localparam logic [NS-1:0] FEN = ~(NS'(1) << 7);
    localparam logic [NS-1:0] NZ  = ~NS'(1);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NS-1:0] src;
    logic [FW-1:0] filt;
    logic [NS-1:0] intr;
    logic [NS-1:0] glitch;

    always #5 clk = ~clk;

    rv_plic_src_filter #(
        .NumSrc(NS), .SyncStages(SS), .FiltW(FW), .FilterEn(FEN)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .src_async_i(src),
        .filt_cycles_i(filt),
        .intr_src_o(intr),
        .glitch_o(glitch)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference model: the input reaches the filter SS edges after sampling;
    // a source takes the new level once it has disagreed with the output for
    // more than filt consecutive cycles. Bypassed sources just copy it.
    logic [NS-1:0] m_line [SS];
    logic [NS-1:0] m_out;
    int            m_run [NS];

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_line[i] = '0;
        m_out = '0;
        for (int s = 0; s < NS; s++) m_run[s] = 0;
    endtask

    task automatic model_step();
        logic [NS-1:0] lvl;
        lvl = m_line[SS-1];
        for (int s = 1; s < NS; s++) begin
            if (!FEN[s]) begin
                m_out[s] = lvl[s];
            end else if (lvl[s] == m_out[s]) begin
                m_run[s] = 0;
            end else if (m_run[s] + 1 > int'(filt)) begin
                m_out[s] = lvl[s];
                m_run[s] = 0;
            end else begin
                m_run[s] = m_run[s] + 1;
            end
        end
        for (int i = SS-1; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = src;
    endtask

    function automatic logic [NS-1:0] model_glitch();
        logic [NS-1:0] g;
        g = '0;
        for (int s = 1; s < NS; s++)
            g[s] = FEN[s] && (m_line[SS-1][s] == m_out[s]) && (m_run[s] != 0);
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_ni) model_reset();
        else model_step();
        @(negedge clk);
        check("intr", intr, m_out);
        check("glitch", glitch, model_glitch());
    endtask

    task automatic pulse(input int idx, input int width, input int window,
                         output int first_hi, output int n_hi, output int n_gl, output int first_gl);
        first_hi = -1; n_hi = 0; n_gl = 0; first_gl = -1;
        src[idx] = 1'b1;
        for (int t = 1; t <= window; t++) begin
            tick();
            if (intr[idx]) begin
                n_hi++;
                if (first_hi < 0) first_hi = t;
            end
            if (glitch[idx]) begin
                n_gl++;
                if (first_gl < 0) first_gl = t;
            end
            if (t == width) src[idx] = 1'b0;
        end
    endtask

    int fh, nh, ng, fg;
    logic [NS-1:0] prev, cur, gl_acc;

    initial begin
        rst_ni = 1'b0;
        src    = '1;
        filt   = 4'd3;
        model_reset();

        // Reset with all lines high
        repeat (3) tick();
        check("rst_intr", intr, '0);
        check("rst_glitch", glitch, '0);
        rst_ni = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 5) check("rise_pre", intr, ~FEN & NZ);
            if (t == 6) check("rise_at", intr, NZ);
        end
        src = '0;
        repeat (12) tick();

        // Glitch rejection and minimum width
        pulse(5, 3, 16, fh, nh, ng, fg);
        check("gl3_hi", NS'(nh), NS'(0));
        check("gl3_cnt", NS'(ng), NS'(1));
        check("gl3_at", NS'(fg), NS'(5));
        pulse(5, 4, 16, fh, nh, ng, fg);
        check("p4_first", NS'(fh), NS'(6));
        check("p4_len", NS'(nh), NS'(4));
        check("p4_gl", NS'(ng), NS'(0));

        // Bypass source and zero-length filter
        filt = 4'd0;
        pulse(7, 1, 8, fh, nh, ng, fg);
        check("byp_first", NS'(fh), NS'(3));
        check("byp_len", NS'(nh), NS'(1));
        check("byp_gl", NS'(ng), NS'(0));
        pulse(8, 1, 8, fh, nh, ng, fg);
        check("f0_first", NS'(fh), NS'(3));
        check("f0_len", NS'(nh), NS'(1));
        check("f0_gl", NS'(ng), NS'(0));

        // Threshold lowered below an in-flight count
        filt = 4'd15;
        src[10] = 1'b1;
        repeat (11) tick();
        check("dyn_pre", NS'(intr[10]), NS'(0));
        filt = 4'd2;
        tick();
        check("dyn_at", NS'(intr[10]), NS'(1));
        src[10] = 1'b0;
        filt = 4'd3;
        repeat (10) tick();

        // Reset in the middle of a falling qualification
        src[12] = 1'b1;
        repeat (10) tick();
        src[12] = 1'b0;
        repeat (4) tick();
        check("mid_hi", NS'(intr[12]), NS'(1));
        src[12] = 1'b1;
        rst_ni = 1'b0;
        #1;
        check("async_rst", intr, '0);
        model_reset();
        repeat (2) tick();
        rst_ni = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 5) check("rq_pre", NS'(intr[12]), NS'(0));
            if (t == 6) check("rq_at", NS'(intr[12]), NS'(1));
        end
        repeat (10) tick();

        // All sources change together
        filt = 4'd4;
        prev = src;
        gl_acc = '0;
        for (int r = 0; r < 6; r++) begin
            cur = NS'({$urandom, $urandom, $urandom});
            src = cur;
            for (int t = 1; t <= 10; t++) begin
                tick();
                gl_acc |= glitch;
                if (t == 6) check("par_hold", intr, ((prev & FEN) | (cur & ~FEN)) & NZ);
                if (t == 7) check("par_at", intr, cur & NZ);
            end
            prev = cur;
        end
        check("par_gl", gl_acc, '0);

        // Random soak with sparse toggles and a moving threshold
        for (int i = 0; i < 400; i++) begin
            src ^= NS'({$urandom, $urandom, $urandom}) & NS'({$urandom, $urandom, $urandom})
                    & NS'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 15) == 0) filt = FW'($urandom_range(0, 15));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
